// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter core; define UART_TX_FIFO_EN to buffer input words in a FIFO_DEPTH-entry FIFO
module uart_tx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Data_Valid,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  par_en,
    input  logic                  PAR_TYP,
    input  logic                  stop2,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  active
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int FW = DATA_WIDTH + 3;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [CW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic [FW-1:0]         hold_q, hold_d;
    logic                  hold_vld_q, hold_vld_d;
    logic                  tx_q, tx_d;
    logic                  active_q, active_d;

    logic                  push;
    logic [FW-1:0]         in_word;
    logic                  hold_fill;
    logic [FW-1:0]         hold_fill_word;
    logic                  next_avail;
    logic [FW-1:0]         next_word;
    logic                  bit_end;
    logic                  stop_end;
    logic                  start_frame;
    logic [FW-1:0]         frame_word;

    assign in_word  = {P_Data, par_en, PAR_TYP, stop2};
    assign bit_end  = (baud_q == BAUD_LAST);
    assign stop_end = (state_q == S_STOP) && bit_end && (!stop2_q || bit_q == CW'(1));

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          full, empty, pop;

    assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = Data_Valid && !full;
    // An idle pop lands in the holding register, so START follows one edge later.
    assign pop            = !empty && ((state_q == S_IDLE && !hold_vld_q) || stop_end);
    assign hold_fill      = pop && (state_q == S_IDLE);
    assign hold_fill_word = mem_q[rd_q];
    assign next_avail     = !empty;
    assign next_word      = mem_q[rd_q];
    assign busy           = full;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_word;
    end
`else
    assign push           = Data_Valid && !active_q;
    assign hold_fill      = push;
    assign hold_fill_word = in_word;
    assign next_avail     = hold_vld_q;
    assign next_word      = hold_q;
    assign busy           = active_q;
`endif

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (hold_vld_q && (state_q == S_IDLE || stop_end)) hold_vld_d = 1'b0;
        if (hold_fill) begin
            hold_d     = hold_fill_word;
            hold_vld_d = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q + 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        start_frame = 1'b0;
        frame_word  = hold_q;
        case (state_q)
            S_IDLE: begin
                baud_d      = '0;
                bit_d       = '0;
                start_frame = hold_vld_q;
            end
            S_START: if (bit_end) begin
                state_d = S_DATA;
                baud_d  = '0;
                bit_d   = '0;
            end
            S_DATA: if (bit_end) begin
                baud_d  = '0;
                shift_d = shift_q >> 1;
                if (bit_q == DATA_LAST) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            S_PARITY: if (bit_end) begin
                state_d = S_STOP;
                baud_d  = '0;
            end
            S_STOP: if (bit_end) begin
                baud_d = '0;
                if (stop_end) begin
                    bit_d = '0;
                    if (next_avail) begin
                        start_frame = 1'b1;
                        frame_word  = next_word;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Frame config is latched here so later input changes cannot reach a frame in flight.
        if (start_frame) begin
            state_d   = S_START;
            baud_d    = '0;
            bit_d     = '0;
            shift_d   = frame_word[FW-1:3];
            par_en_d  = frame_word[2];
            stop2_d   = frame_word[0];
            par_bit_d = (^frame_word[FW-1:3]) ^ frame_word[1];
        end
    end

    always_comb begin
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            tx_q       <= 1'b1;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            tx_q       <= tx_d;
            active_q   <= active_d;
        end
    end

    assign TX_OUT = tx_q;
    assign active = active_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - self-checking bench for uart_tx_core (DATA_WIDTH=8, BAUD_DIV=4)
module tb_uart_tx_core;
    localparam int DW = 8;
    localparam int BD = 4;
`ifdef UART_TX_FIFO_EN
    localparam int   LAT           = 2;
    localparam logic BUSY_IN_FRAME = 1'b0;
`else
    localparam int   LAT           = 1;
    localparam logic BUSY_IN_FRAME = 1'b1;
`endif

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          Data_Valid = 1'b0;
    logic [DW-1:0] P_Data     = '0;
    logic          par_en     = 1'b0;
    logic          PAR_TYP    = 1'b0;
    logic          stop2      = 1'b0;
    logic          TX_OUT, busy, active;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_core #(.DATA_WIDTH(DW), .BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .Data_Valid(Data_Valid), .P_Data(P_Data),
        .par_en(par_en), .PAR_TYP(PAR_TYP), .stop2(stop2),
        .TX_OUT(TX_OUT), .busy(busy), .active(active)
    );

    always #5 clk = ~clk;

    // Reference: a frame is a list of bits, each held BD cycles.
    function automatic int flen(input bit pe, input bit s2);
        return BD * (1 + DW + int'(pe) + 1 + int'(s2));
    endfunction

    function automatic logic exp_tx(input logic [DW-1:0] d, input bit pe, input bit pt, input int c);
        int b = c / BD;
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
        if (pe && b == DW + 1) return (^d) ^ pt;
        return 1'b1;
    endfunction

    task automatic offer(input logic [DW-1:0] d, input bit pe, input bit pt, input bit s2);
        Data_Valid = 1'b1; P_Data = d; par_en = pe; PAR_TYP = pt; stop2 = s2;
        @(negedge clk);
        Data_Valid = 1'b0; P_Data = DW'($urandom);
        par_en = 1'($urandom); PAR_TYP = 1'($urandom); stop2 = 1'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; Data_Valid = 1'b1; P_Data = 8'h00;
        repeat (3) @(negedge clk);
        vectors++;
        if (TX_OUT !== 1'b1 || active !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: tx=%b active=%b busy=%b, expected 1/0/0", TX_OUT, active, busy);
        end
        reset = 1'b0; Data_Valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            vectors++;
            if (TX_OUT !== 1'b1 || active !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_accept c=%0d: tx=%b active=%b, expected 1/0", c, TX_OUT, active);
            end
        end
    endtask

    task automatic test_frame_a5();
        logic [10:0] a5_exp = 11'b10101001010;
        int act_cnt = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        offer(8'hA5, 1'b1, 1'b0, 1'b0);
        repeat (LAT) @(negedge clk);
        for (int c = 0; c < 48; c++) begin
            if (active === 1'b1) act_cnt++;
            if (c < 44) begin
                vectors++;
                if (TX_OUT !== a5_exp[c / BD]) begin
                    miscompares++;
                    $display("FAIL a5_bits c=%0d: tx=%b, expected %b", c, TX_OUT, a5_exp[c / BD]);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (act_cnt !== 44) begin
            miscompares++;
            $display("FAIL a5_active_len: got %0d cycles, expected 44", act_cnt);
        end
        vectors++;
        if (TX_OUT !== 1'b1 || active !== 1'b0) begin
            miscompares++;
            $display("FAIL a5_idle: tx=%b active=%b, expected 1/0", TX_OUT, active);
        end
    endtask

    task automatic test_parity_stop2();
        int act_cnt = 0;
        offer(8'h00, 1'b1, 1'b1, 1'b1);
        repeat (LAT) @(negedge clk);
        for (int c = 0; c < 48; c++) begin
            if (active === 1'b1) act_cnt++;
            vectors++;
            if (TX_OUT !== exp_tx(8'h00, 1'b1, 1'b1, c)) begin
                miscompares++;
                $display("FAIL odd_par_stop2 c=%0d: tx=%b, expected %b", c, TX_OUT, exp_tx(8'h00, 1'b1, 1'b1, c));
            end
            if (c == 38) begin
                vectors++;
                if (TX_OUT !== 1'b1) begin
                    miscompares++;
                    $display("FAIL odd_parity_bit: tx=%b, expected 1", TX_OUT);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (act_cnt !== 48 || TX_OUT !== 1'b1 || active !== 1'b0) begin
            miscompares++;
            $display("FAIL stop2_len_idle: active cycles=%0d tx=%b active=%b, expected 48/1/0", act_cnt, TX_OUT, active);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            logic [DW-1:0] d = DW'($urandom);
            bit pe = 1'($urandom);
            bit pt = 1'($urandom);
            bit s2 = 1'($urandom);
            offer(d, pe, pt, s2);
            repeat (LAT) @(negedge clk);
            for (int c = 0; c < flen(pe, s2); c++) begin
                vectors++;
                if (TX_OUT !== exp_tx(d, pe, pt, c) || active !== 1'b1 || busy !== BUSY_IN_FRAME) begin
                    miscompares++;
                    $display("FAIL random d=%h pe=%b pt=%b s2=%b c=%0d: tx=%b active=%b busy=%b, expected %b/1/%b",
                             d, pe, pt, s2, c, TX_OUT, active, busy, exp_tx(d, pe, pt, c), BUSY_IN_FRAME);
                end
                @(negedge clk);
            end
            vectors++;
            if (TX_OUT !== 1'b1 || active !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL random_idle n=%0d: tx=%b active=%b busy=%b, expected 1/0/0", n, TX_OUT, active, busy);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

`ifndef UART_TX_FIFO_EN
    task automatic test_busy_ignore();
        bit pe = 1'($urandom);
        bit pt = 1'($urandom);
        bit s2 = 1'($urandom);
        int bad = 0;
        offer(8'h3C, pe, pt, s2);
        repeat (LAT) @(negedge clk);
        for (int c = 0; c < flen(pe, s2); c++) begin
            vectors++;
            if (TX_OUT !== exp_tx(8'h3C, pe, pt, c) || active !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_ignore_frame c=%0d: tx=%b active=%b, expected %b/1", c, TX_OUT, active, exp_tx(8'h3C, pe, pt, c));
            end
            if (c >= 20 && c < 23) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_mid_frame c=%0d: busy=%b, expected 1", c, busy);
                end
                Data_Valid = 1'b1; P_Data = 8'hFF;
            end else begin
                Data_Valid = 1'b0;
            end
            @(negedge clk);
        end
        for (int c = 0; c < 2 * flen(1'b1, 1'b1); c++) begin
            if (TX_OUT !== 1'b1 || active !== 1'b0) bad++;
            @(negedge clk);
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL busy_ignore_no_ff: %0d non-idle cycles after frame, expected 0", bad);
        end
    endtask
`endif

    task automatic test_reset_midframe();
        logic [DW-1:0] d = DW'($urandom);
        bit pe = 1'($urandom);
        bit pt = 1'($urandom);
        bit s2 = 1'($urandom);
        offer(d, pe, pt, s2);
        repeat (LAT) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (TX_OUT !== exp_tx(d, pe, pt, c) || active !== 1'b1) begin
                miscompares++;
                $display("FAIL pre_reset c=%0d: tx=%b active=%b, expected %b/1", c, TX_OUT, active, exp_tx(d, pe, pt, c));
            end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (TX_OUT !== 1'b1 || active !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: tx=%b active=%b busy=%b, expected 1/0/0", TX_OUT, active, busy);
        end
        pe = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
        offer(8'h55, pe, pt, s2);
        repeat (LAT) @(negedge clk);
        for (int c = 0; c < flen(pe, s2); c++) begin
            vectors++;
            if (TX_OUT !== exp_tx(8'h55, pe, pt, c) || active !== 1'b1) begin
                miscompares++;
                $display("FAIL post_reset_55 c=%0d: tx=%b active=%b, expected %b/1", c, TX_OUT, active, exp_tx(8'h55, pe, pt, c));
            end
            @(negedge clk);
        end
        vectors++;
        if (TX_OUT !== 1'b1 || active !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: tx=%b active=%b, expected 1/0", TX_OUT, active);
        end
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_back_to_back();
        logic [DW-1:0] wd [6];
        bit pe_a [6];
        bit pt_a [6];
        bit s2_a [6];
        int total = 0;
        for (int i = 0; i < 6; i++) begin
            wd[i] = DW'(i + 1); pe_a[i] = 1'($urandom); pt_a[i] = 1'($urandom); s2_a[i] = 1'($urandom);
            if (i < 5) total += flen(pe_a[i], s2_a[i]);
        end
        Data_Valid = 1'b1; P_Data = wd[0]; par_en = pe_a[0]; PAR_TYP = pt_a[0]; stop2 = s2_a[0];
        for (int j = 0; j < total + 6; j++) begin
            int s = j - 2;
            @(negedge clk);
            if (j < 6) begin
                vectors++;
                if (busy !== (j >= 4)) begin
                    miscompares++;
                    $display("FAIL fifo_busy j=%0d: busy=%b, expected %b", j, busy, (j >= 4));
                end
            end
            if (j < 5) begin
                P_Data = wd[j+1]; par_en = pe_a[j+1]; PAR_TYP = pt_a[j+1]; stop2 = s2_a[j+1];
            end else begin
                Data_Valid = 1'b0;
            end
            if (s >= 0 && s < total) begin
                int f = 0;
                int off = s;
                while (off >= flen(pe_a[f], s2_a[f])) begin
                    off -= flen(pe_a[f], s2_a[f]);
                    f++;
                end
                vectors++;
                if (TX_OUT !== exp_tx(wd[f], pe_a[f], pt_a[f], off) || active !== 1'b1) begin
                    miscompares++;
                    $display("FAIL fifo_frames f=%0d off=%0d: tx=%b active=%b, expected %b/1",
                             f, off, TX_OUT, active, exp_tx(wd[f], pe_a[f], pt_a[f], off));
                end
            end else if (s >= total) begin
                vectors++;
                if (TX_OUT !== 1'b1 || active !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fifo_tail s=%0d: tx=%b active=%b, expected 1/0", s, TX_OUT, active);
                end
            end
        end
    endtask
`else
    task automatic test_back_to_back();
        logic [DW-1:0] w0 = DW'($urandom);
        logic [DW-1:0] w1 = DW'($urandom);
        bit pe0 = 1'($urandom), pt0 = 1'($urandom), s20 = 1'($urandom);
        bit pe1 = 1'($urandom), pt1 = 1'($urandom), s21 = 1'($urandom);
        int l0 = flen(pe0, s20);
        int l1 = flen(pe1, s21);
        Data_Valid = 1'b1; P_Data = w0; par_en = pe0; PAR_TYP = pt0; stop2 = s20;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_busy_after_accept: busy=%b, expected 0", busy);
        end
        P_Data = w1; par_en = pe1; PAR_TYP = pt1; stop2 = s21;
        @(negedge clk);
        Data_Valid = 1'b0;
        for (int c = 0; c < l0 + l1; c++) begin
            logic e = (c < l0) ? exp_tx(w0, pe0, pt0, c) : exp_tx(w1, pe1, pt1, c - l0);
            vectors++;
            if (TX_OUT !== e || active !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b c=%0d: tx=%b active=%b, expected %b/1", c, TX_OUT, active, e);
            end
            @(negedge clk);
        end
        vectors++;
        if (TX_OUT !== 1'b1 || active !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: tx=%b active=%b, expected 1/0", TX_OUT, active);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_a5();
        test_parity_stop2();
        test_random();
`ifndef UART_TX_FIFO_EN
        test_busy_ignore();
`endif
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
